// File: rtl/ft_err_pkg.sv
// ft_err_pkg: shared types and helpers for the voter error collector.
// FT_ERR_TIMESTAMP_EN adds a 16-bit enqueue timestamp to each event.
package ft_err_pkg;

    localparam int FT_ERR_TS_W     = 16;
    localparam int FT_ERR_ID_MAX_W = 5;

    function automatic int ft_err_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
`ifdef FT_ERR_TIMESTAMP_EN
        logic [FT_ERR_TS_W-1:0]     ts;
`endif
        logic [FT_ERR_ID_MAX_W-1:0] id;
    } ft_err_evt_t;

endpackage

// File: rtl/ft_err_fifo.sv
// ft_err_fifo: shift-register event FIFO; entry 0 is the registered head.
// Flush empties the queue and zeroes the head entry.
module ft_err_fifo
    import ft_err_pkg::*;
#(
    parameter type T     = ft_err_evt_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    T            mem [DEPTH];
    logic [AW:0] count;
    logic        do_pop;
    logic        do_push;
    logic [AW-1:0] wr_idx;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[0];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_idx  = do_pop ? AW'(count - (AW+1)'(1)) : AW'(count);

    // Shift down on pop, write behind the last live entry on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
            end
            if (do_push) mem[wr_idx] <= din;
            if (do_push && !do_pop) count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ft_err_collector.sv
// ft_err_collector: per-source TMR voter error statistics and event queue.
// FT_ERR_TIMESTAMP_EN adds a free-running cycle counter and evt_ts_o.
module ft_err_collector
    import ft_err_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int THRESH     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_SRC-1:0]              err_i,
    input  logic                          clear_i,
    output logic                          evt_valid_o,
    input  logic                          evt_ready_i,
    output logic [ft_err_id_w(N_SRC)-1:0] evt_id_o,
`ifdef FT_ERR_TIMESTAMP_EN
    output logic [FT_ERR_TS_W-1:0]        evt_ts_o,
`endif
    output logic [N_SRC*CNT_W-1:0]        err_cnt_o,
    output logic [N_SRC-1:0]              sticky_o,
    output logic [N_SRC-1:0]              overrun_o,
    output logic                          alarm_o,
    output logic                          fifo_full_o
);

    localparam int ID_W = ft_err_id_w(N_SRC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    logic [CNT_W-1:0] cnt     [N_SRC];
    logic [CNT_W-1:0] cnt_nxt [N_SRC];
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] sel_oh;
    logic [N_SRC-1:0] enq_oh;
    logic [ID_W-1:0]  sel;
    logic             alarm_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    ft_err_evt_t      evt_in;
    ft_err_evt_t      evt_head;

    assign req    = pending | err_i;
    assign sel_oh = req & (~req + N_SRC'(1));
    assign pop    = evt_valid_o & evt_ready_i;
    assign push   = (|req) && (!fifo_full || pop) && !clear_i;
    assign enq_oh = push ? sel_oh : '0;

    // Lowest-index requesting source wins the enqueue slot.
    always_comb begin
        sel = '0;
        for (int k = N_SRC-1; k >= 0; k--) begin
            if (req[k]) sel = ID_W'(k);
        end
    end

    // Saturating counter next-state and the alarm it implies.
    always_comb begin
        alarm_nxt = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            cnt_nxt[k] = cnt[k];
            if (clear_i) cnt_nxt[k] = '0;
            else if (err_i[k] && cnt[k] != CNT_MAX) cnt_nxt[k] = cnt[k] + CNT_W'(1);
            if (cnt_nxt[k] >= THR) alarm_nxt = 1'b1;
        end
    end

    // Statistics and pending state; clear wins over same-cycle errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_SRC; k++) cnt[k] <= '0;
            sticky_o  <= '0;
            overrun_o <= '0;
            pending   <= '0;
            alarm_o   <= 1'b0;
        end else if (clear_i) begin
            for (int k = 0; k < N_SRC; k++) cnt[k] <= '0;
            sticky_o  <= '0;
            overrun_o <= '0;
            pending   <= '0;
            alarm_o   <= 1'b0;
        end else begin
            for (int k = 0; k < N_SRC; k++) cnt[k] <= cnt_nxt[k];
            sticky_o  <= sticky_o | err_i;
            overrun_o <= overrun_o | (err_i & pending & ~enq_oh);
            pending   <= req & ~enq_oh;
            alarm_o   <= alarm_nxt;
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        err_cnt_o = '0;
        for (int k = 0; k < N_SRC; k++) err_cnt_o[k*CNT_W +: CNT_W] = cnt[k];
    end

`ifdef FT_ERR_TIMESTAMP_EN
    logic [FT_ERR_TS_W-1:0] ts;

    // Free-running cycle counter, untouched by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else ts <= ts + FT_ERR_TS_W'(1);
    end

    assign evt_in.ts = ts;
    assign evt_ts_o  = evt_head.ts;
`endif

    assign evt_in.id = FT_ERR_ID_MAX_W'(sel);

    ft_err_fifo #(
        .T     (ft_err_evt_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear_i),
        .push  (push),
        .pop   (pop),
        .din   (evt_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (evt_head)
    );

    assign evt_valid_o = !fifo_empty;
    assign evt_id_o    = ID_W'(evt_head.id);
    assign fifo_full_o = fifo_full;

endmodule

// File: tb/tb_ft_err_collector.sv
// tb_ft_err_collector: vector table, corner sequences and random stimulus
// against a queue-based reference model of the error collector.
module tb_ft_err_collector;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int TH = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        ready = 1'b0;
    logic [3:0]  err   = '0;
    logic        valid;
    logic        full;
    logic        alarm;
    logic [1:0]  id;
    logic [31:0] cnts;
    logic [3:0]  sticky;
    logic [3:0]  ovr;
`ifdef FT_ERR_TIMESTAMP_EN
    logic [15:0] ts;
`endif

    int errors = 0;
    int checks = 0;

    int m_cnt  [N];
    bit m_st   [N];
    bit m_ovr  [N];
    bit m_pend [N];
    int q   [$];
    int qts [$];
    int m_tsc;

    typedef struct {
        logic [3:0] err;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic [3:0] exp_sticky;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    ft_err_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .err_i       (err),
        .clear_i     (clear),
        .evt_valid_o (valid),
        .evt_ready_i (ready),
        .evt_id_o    (id),
`ifdef FT_ERR_TIMESTAMP_EN
        .evt_ts_o    (ts),
`endif
        .err_cnt_o   (cnts),
        .sticky_o    (sticky),
        .overrun_o   (ovr),
        .alarm_o     (alarm),
        .fifo_full_o (full)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_st[k] = 0; m_ovr[k] = 0; m_pend[k] = 0;
        end
        q.delete();
        qts.delete();
        m_tsc = 0;
    endtask

    task automatic model_edge(input logic [3:0] e, input logic c, input logic r);
        bit popd;
        int enq;
        if (c) begin
            for (int k = 0; k < N; k++) begin
                m_cnt[k] = 0; m_st[k] = 0; m_ovr[k] = 0; m_pend[k] = 0;
            end
            q.delete();
            qts.delete();
        end else begin
            popd = (q.size() > 0) && r;
            for (int k = 0; k < N; k++) begin
                if (e[k]) begin
                    if (m_cnt[k] < 255) m_cnt[k]++;
                    m_st[k] = 1;
                end
            end
            if (popd) begin
                void'(q.pop_front());
                void'(qts.pop_front());
            end
            enq = -1;
            if (q.size() < D) begin
                for (int k = 0; k < N; k++)
                    if (enq < 0 && (m_pend[k] || e[k])) enq = k;
            end
            if (enq >= 0) begin
                q.push_back(enq);
                qts.push_back(m_tsc);
            end
            for (int k = 0; k < N; k++) begin
                if (e[k] && m_pend[k] && k != enq) m_ovr[k] = 1;
                m_pend[k] = (m_pend[k] || e[k]) && k != enq;
            end
        end
        m_tsc = (m_tsc + 1) % 65536;
    endtask

    task automatic compare_all();
        longint ec = 0;
        int est = 0;
        int eov = 0;
        bit eal = 0;
        for (int k = 0; k < N; k++) begin
            ec |= longint'(m_cnt[k]) << (8 * k);
            if (m_cnt[k] >= TH) eal = 1;
            if (m_st[k]) est |= (1 << k);
            if (m_ovr[k]) eov |= (1 << k);
        end
        chk("valid", valid, q.size() > 0);
        if (q.size() > 0) chk("id", id, q[0]);
`ifdef FT_ERR_TIMESTAMP_EN
        if (q.size() > 0) chk("ts", ts, qts[0]);
`endif
        chk("cnt", cnts, ec);
        chk("sticky", sticky, est);
        chk("overrun", ovr, eov);
        chk("alarm", alarm, eal);
        chk("full", full, q.size() == D);
    endtask

    task automatic step(input logic [3:0] e, input logic c, input logic r);
        err = e;
        clear = c;
        ready = r;
        @(posedge clk);
        model_edge(e, c, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        tbl[0] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[1] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0100};
        tbl[2] = '{4'b1011, 1'b1, 1'b1, 2'd0, 4'b1111};
        tbl[3] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b1111};
        tbl[4] = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b1111};
        tbl[5] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b1111};

        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_id", id, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step(tbl[i].err, 1'b0, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_id", i), id, tbl[i].exp_id);
            chk($sformatf("tbl%0d_sticky", i), sticky, tbl[i].exp_sticky);
        end
        chk("simul_overrun", ovr, 0);
        chk("simul_cnt", cnts, 32'h0101_0101 & 32'hff00_ffff | 32'h0001_0000);

        step(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(4'b0001, 1'b0, 1'b0);
            chk("bp_id", id, 0);
        end
        chk("bp_full", full, 1);
        chk("bp_overrun0", ovr[0], 1);
        chk("bp_cnt0", cnts[7:0], 10);

        step(4'b0000, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b1);
        chk("clr_cnt", cnts, 0);
        chk("clr_sticky", sticky, 0);
        chk("clr_valid", valid, 0);
        chk("clr_alarm", alarm, 0);

        for (int i = 0; i < 300; i++) begin
            step(4'b0010, 1'b0, 1'b1);
            if (i == 14) chk("sat_alarm_low", alarm, 0);
            if (i == 15) begin
                chk("sat_alarm_rise", alarm, 1);
                chk("sat_cnt16", cnts[15:8], 16);
            end
        end
        chk("sat_cnt_max", cnts[15:8], 255);

        step(4'b0000, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0101, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_cnt", cnts, 0);
        chk("arst_sticky", sticky, 0);
        chk("arst_overrun", ovr, 0);
        chk("arst_full", full, 0);
        chk("arst_id", id, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] e;
            logic c;
            logic r;
            e = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 3) >= ((i / 500) % 2 == 1 ? 3 : 1));
            step(e, c, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
